// File: rtl/regfile_pkg.sv
// Shared constants and encodings for the register-file arbiter slice.
// Optional feature macro used by the slice: REGFILE_R0_ZERO_EN (register 0 hard-wired to zero).
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-granted pointer.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Remembers who won last; starting at B gives A priority after reset.
  req_id_t last_q;

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_A] && req[REQ_B]) begin
      gnt[other_req(last_q)] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else if (accept && (|req)) begin
      last_q <= gnt[REQ_B] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin shared access port for a 32x32 register file with a post-reset clear sweep.
// Optional feature macro: REGFILE_R0_ZERO_EN (register 0 reads as zero, writes to it suppressed).
module regfile_arbiter #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReqA,
  input  logic              iWeA,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iWdataA,
  output logic              oGntA,
  output logic [DATA_W-1:0] oRdataA,
  output logic              oRvalidA,
  input  logic              iReqB,
  input  logic              iWeB,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [DATA_W-1:0] iWdataB,
  output logic              oGntB,
  output logic [DATA_W-1:0] oRdataB,
  output logic              oRvalidB,
  output logic              oRfEna,
  output logic              oRfWe,
  output logic [ADDR_W-1:0] oRfAddr,
  output logic [DATA_W-1:0] oRfWdata,
  input  logic [DATA_W-1:0] iRfRdata,
  output logic              oBusy
);
  import regfile_pkg::*;

  // Handshake: a requester raises iReqX with stable iWeX/iAddrX/iWdataX and holds it until
  // oGntX pulses for one cycle; the access is issued in that same cycle. A read then returns
  // one cycle later with a one-cycle oRvalidX pulse. oBusy=1 means requests are ignored.

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;

  logic              rd_pend;
  req_id_t           rd_id;
  logic              rd_zero;

  logic [1:0]        elig;
  logic [1:0]        gnt;
  req_id_t           win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_r0;

  // Masking with the current grant keeps a request held one cycle too long from winning twice.
  assign elig[REQ_A] = iReqA & ~oGntA;
  assign elig[REQ_B] = iReqB & ~oGntB;

  rr_arbiter2 u_arb (
    .clk    (iClk),
    .rst    (iRst),
    .req    (elig),
    .accept (state == ST_RUN),
    .gnt    (gnt)
  );

  always_comb begin
    win_id    = gnt[REQ_B] ? REQ_B : REQ_A;
    win_we    = iWeA;
    win_addr  = iAddrA;
    win_wdata = iWdataA;
    if (win_id == REQ_B) begin
      win_we    = iWeB;
      win_addr  = iAddrB;
      win_wdata = iWdataB;
    end
  end

`ifdef REGFILE_R0_ZERO_EN
  assign win_r0 = (win_addr == '0);
`else
  assign win_r0 = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      oGntA     <= 1'b0;
      oGntB     <= 1'b0;
      oRvalidA  <= 1'b0;
      oRvalidB  <= 1'b0;
      oRdataA   <= '0;
      oRdataB   <= '0;
      oRfEna    <= 1'b0;
      oRfWe     <= 1'b0;
      oRfAddr   <= '0;
      oRfWdata  <= '0;
      oBusy     <= 1'b1;
      rd_pend   <= 1'b0;
      rd_id     <= REQ_A;
      rd_zero   <= 1'b0;
    end else begin
      oGntA    <= 1'b0;
      oGntB    <= 1'b0;
      oRvalidA <= 1'b0;
      oRvalidB <= 1'b0;
      oRfEna   <= 1'b0;
      oRfWe    <= 1'b0;
      rd_pend  <= 1'b0;

      // Read data is valid on iRfRdata during the cycle the read address is presented.
      if (rd_pend) begin
        if (rd_id == REQ_A) begin
          oRdataA  <= rd_zero ? '0 : iRfRdata;
          oRvalidA <= 1'b1;
        end else begin
          oRdataB  <= rd_zero ? '0 : iRfRdata;
          oRvalidB <= 1'b1;
        end
      end

      case (state)
        ST_INIT: begin
          oRfEna    <= 1'b1;
          oRfWe     <= 1'b1;
          oRfAddr   <= sweep_cnt;
          oRfWdata  <= '0;
          sweep_cnt <= sweep_cnt + ADDR_W'(1);
          if (&sweep_cnt) begin
            state <= ST_RUN;
            oBusy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (|gnt) begin
            oGntA    <= gnt[REQ_A];
            oGntB    <= gnt[REQ_B];
            oRfEna   <= 1'b1;
            oRfWe    <= win_we & ~win_r0;
            oRfAddr  <= win_addr;
            oRfWdata <= win_wdata;
            rd_pend  <= ~win_we;
            rd_id    <= win_id;
            rd_zero  <= win_r0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
